ram_prog_loader: RTL and testbench

Front-end programming stage that sits directly upstream of `eightBit` and its 16×8 RAM. It synchronises the raw programming pins (prog mode, address, data, write button), debounces the write button, and issues single-cycle RAM write strobes. It also holds the CPU in halt/reset while programming, and releases it cleanly with a fixed reset pulse when programming ends.

---
 rtl/ram_prog_loader.sv | 144 ++++++++++++++
 tb/tb_ram_prog_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_prog_loader.sv
// Programming front end for the eightBit 16x8 RAM. Synchronises and debounces the
// programming pins, issues one-cycle write strobes, and holds the CPU while loading.
module ram_prog_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_mode_in,
  input  logic [3:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       wr_btn,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       cpu_halt,
  output logic       cpu_rst_n,
  output logic [7:0] wr_count
);

  typedef enum logic [1:0] {RUN, PROG_IDLE, WRITE, EXIT} state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);

  logic       prog_s1, prog_s2;
  logic       btn_s1, btn_s2;
  logic [3:0] addr_s1, addr_s2;
  logic [7:0] data_s1, data_s2;

  logic       btn_db;
  logic       press;
  logic [7:0] db_cnt;
  logic [7:0] hold_cnt;

  state_t state, state_next;
  logic   capture;
  logic   count_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_s1 <= 1'b0;
      prog_s2 <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      addr_s1 <= '0;
      addr_s2 <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      prog_s1 <= prog_mode_in;
      prog_s2 <= prog_s1;
      btn_s1  <= wr_btn;
      btn_s2  <= btn_s1;
      addr_s1 <= addr_in;
      addr_s2 <= addr_s1;
      data_s1 <= data_in;
      data_s2 <= data_s1;
    end
  end

  // A level change is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // press pulses for the single cycle following an accepted rising level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
        press  <= ~btn_db;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    count_clr  = 1'b0;
    case (state)
      RUN: begin
        if (prog_s2) begin
          state_next = PROG_IDLE;
          count_clr  = 1'b1;
        end
      end
      PROG_IDLE: begin
        if (press) begin
          state_next = WRITE;
          capture    = 1'b1;
        end else if (!prog_s2) begin
          state_next = EXIT;
        end
      end
      WRITE: state_next = PROG_IDLE;
      EXIT: begin
        if (prog_s2) begin
          state_next = PROG_IDLE;
          count_clr  = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
        end
      end
      default: state_next = EXIT;
    endcase
  end

  // CPU controls are registered from the next state so they can never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EXIT;
      hold_cnt  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_halt  <= 1'b1;
      cpu_rst_n <= 1'b0;
      wr_count  <= '0;
    end else begin
      state     <= state_next;
      ram_we    <= capture;
      cpu_halt  <= (state_next != RUN);
      cpu_rst_n <= (state_next == RUN);
      hold_cnt  <= (state == EXIT && state_next == EXIT) ? hold_cnt + 8'd1 : 8'd0;
      if (capture) begin
        ram_addr  <= addr_s2;
        ram_wdata <= data_s2;
        if (wr_count != 8'hFF) begin
          wr_count <= wr_count + 8'd1;
        end
      end else if (count_clr) begin
        wr_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_prog_loader.sv
// Self-checking bench for ram_prog_loader: a table of write vectors, hand-built corner
// sequences and randomized pin traffic, all scored against a cycle-level reference model.
module tb_ram_prog_loader;

  localparam int DB   = 4;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_mode_in = 1'b0;
  logic [3:0] addr_in = '0;
  logic [7:0] data_in = '0;
  logic       wr_btn = 1'b0;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_halt;
  logic       cpu_rst_n;
  logic [7:0] wr_count;

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;
  bit model_on = 1'b0;

  ram_prog_loader #(.DEBOUNCE_CYCLES(DB), .RESET_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .prog_mode_in(prog_mode_in), .addr_in(addr_in),
    .data_in(data_in), .wr_btn(wr_btn), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_halt(cpu_halt), .cpu_rst_n(cpu_rst_n), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: pins reach the logic two edges late, the button is accepted after DB
  // disagreeing samples, and the mode is "programming", "strobing" or "reset cycles left".
  logic [1:0] hp = '0, hb = '0;
  logic [3:0] ha0 = '0, ha1 = '0;
  logic [7:0] hd0 = '0, hd1 = '0;
  bit         acc = 0, press_pend = 0, pr, sp, sb;
  int         run = 0;
  logic [3:0] sa;
  logic [7:0] sd;
  bit         m_prog = 0, m_we = 0;
  int         exit_left = HOLD;
  int         m_count = 0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp = '0; hb = '0; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
      acc = 0; press_pend = 0; run = 0;
      m_prog = 0; m_we = 0; exit_left = HOLD; m_count = 0; m_addr = '0; m_data = '0;
    end else begin
      sp = hp[1]; sb = hb[1]; sa = ha1; sd = hd1;
      hp = {hp[0], prog_mode_in};
      hb = {hb[0], wr_btn};
      ha1 = ha0; ha0 = addr_in;
      hd1 = hd0; hd0 = data_in;
      pr = press_pend;
      press_pend = 0;
      if (m_we) begin
        m_we = 0;
      end else if (m_prog) begin
        if (pr) begin
          m_we = 1; m_addr = sa; m_data = sd;
          if (m_count < 255) m_count++;
        end else if (!sp) begin
          m_prog = 0; exit_left = HOLD;
        end
      end else if (exit_left > 0) begin
        if (sp) begin m_prog = 1; exit_left = 0; m_count = 0; end
        else exit_left--;
      end else if (sp) begin
        m_prog = 1; m_count = 0;
      end
      if (sb != acc) begin
        run++;
        if (run == DB) begin acc = !acc; run = 0; press_pend = acc; end
      end else begin
        run = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      checkOutput("model ram_we", ram_we, m_we);
      checkOutput("model ram_addr", ram_addr, m_addr);
      checkOutput("model ram_wdata", ram_wdata, m_data);
      checkOutput("model cpu_halt", cpu_halt, (m_prog || exit_left > 0));
      checkOutput("model cpu_rst_n", cpu_rst_n, (!m_prog && exit_left == 0));
      checkOutput("model wr_count", wr_count, m_count);
    end
    if (rst_n && ram_we) we_pulses++;
  end

  task automatic applyStimulus(input bit prog, input bit btn, input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_mode_in = prog;
    wr_btn = btn;
    addr_in = addr;
    data_in = data;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the button for hold rising edges and reports the edge on which ram_we appeared.
  task automatic pressButton(input int hold, input int release_cycles, output int lat);
    lat = 0;
    applyStimulus(prog_mode_in, 1'b1, addr_in, data_in);
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (ram_we && lat == 0) lat = i;
    end
    applyStimulus(prog_mode_in, 1'b0, addr_in, data_in);
    idle(release_cycles);
  endtask

  task automatic edgesUntil(input bit want_rst, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(want_rst ? cpu_rst_n : ram_we) && n < limit);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ram_we"}, ram_we, 0);
    checkOutput({tag, " ram_addr"}, ram_addr, 0);
    checkOutput({tag, " ram_wdata"}, ram_wdata, 0);
    checkOutput({tag, " cpu_halt"}, cpu_halt, 1);
    checkOutput({tag, " cpu_rst_n"}, cpu_rst_n, 0);
    checkOutput({tag, " wr_count"}, wr_count, 0);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         hold;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
    int         exp_count;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];
  int lat, n, m, seg;
  bit p, b;
  logic [3:0] a;
  logic [7:0] d;

  initial begin
    vecs[0] = '{4'h0, 8'h00,  8, 4'h0, 8'h00, 2, 7};
    vecs[1] = '{4'hF, 8'hFF, 12, 4'hF, 8'hFF, 3, 7};
    vecs[2] = '{4'h5, 8'hA5, 20, 4'h5, 8'hA5, 4, 7};
    vecs[3] = '{4'h9, 8'h5A,  9, 4'h9, 8'h5A, 5, 7};
    vecs[4] = '{4'h1, 8'h80, 30, 4'h1, 8'h80, 6, 7};
    vecs[5] = '{4'hE, 8'h01, 10, 4'hE, 8'h01, 7, 7};

    // Reset state and release timing with prog low
    applyStimulus(0, 0, 4'h0, 8'h00);
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
    we_pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      checkOutput("release cpu_rst_n", cpu_rst_n, (i >= HOLD));
      checkOutput("release cpu_halt", cpu_halt, (i < HOLD));
    end
    checkOutput("release no strobe", we_pulses, 0);

    // First clean press
    applyStimulus(1, 0, 4'hA, 8'h3C);
    idle(6);
    we_pulses = 0;
    pressButton(20, 8, lat);
    checkOutput("first latency", lat, 7);
    checkOutput("first ram_addr", ram_addr, 4'hA);
    checkOutput("first ram_wdata", ram_wdata, 8'h3C);
    checkOutput("first wr_count", wr_count, 1);
    checkOutput("first pulses", we_pulses, 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, vecs[i].addr, vecs[i].data);
      idle(3);
      pressButton(vecs[i].hold, 8, lat);
      checkOutput("vec latency", lat, vecs[i].exp_lat);
      checkOutput("vec ram_addr", ram_addr, vecs[i].exp_addr);
      checkOutput("vec ram_wdata", ram_wdata, vecs[i].exp_data);
      checkOutput("vec wr_count", wr_count, vecs[i].exp_count);
    end

    // Bounce, then a too-short release, then a proper release and press
    we_pulses = 0;
    applyStimulus(1, 1, 4'h6, 8'h66);
    applyStimulus(1, 1, 4'h6, 8'h66);
    applyStimulus(1, 0, 4'h6, 8'h66);
    applyStimulus(1, 0, 4'h6, 8'h66);
    applyStimulus(1, 1, 4'h6, 8'h66);
    applyStimulus(1, 1, 4'h6, 8'h66);
    applyStimulus(1, 0, 4'h6, 8'h66);
    applyStimulus(1, 0, 4'h6, 8'h66);
    checkOutput("bounce no write", we_pulses, 0);
    pressButton(12, 1, lat);
    checkOutput("bounce latency", lat, 7);
    pressButton(12, 8, lat);
    checkOutput("short release no write", lat, 0);
    checkOutput("short release pulses", we_pulses, 1);
    pressButton(12, 8, lat);
    checkOutput("repress latency", lat, 7);
    checkOutput("repress pulses", we_pulses, 2);
    checkOutput("bounce wr_count", wr_count, 9);

    // Prog drops in the very cycle the press is detected
    applyStimulus(1, 0, 4'h3, 8'hFF);
    idle(3);
    we_pulses = 0;
    applyStimulus(1, 1, 4'h3, 8'hFF);
    idle(3);
    applyStimulus(0, 1, 4'h3, 8'hFF);
    edgesUntil(0, 30, n);
    checkOutput("drop write edge", n, 3);
    checkOutput("drop ram_addr", ram_addr, 4'h3);
    checkOutput("drop ram_wdata", ram_wdata, 8'hFF);
    edgesUntil(1, 30, m);
    checkOutput("drop to run", m, 6);
    checkOutput("drop pulses", we_pulses, 1);
    applyStimulus(0, 0, 4'h3, 8'hFF);
    idle(8);

    // Prog re-asserted two cycles into the exit hold
    applyStimulus(1, 0, 4'h7, 8'h42);
    idle(4);
    pressButton(10, 8, lat);
    checkOutput("pre-exit wr_count", wr_count, 1);
    applyStimulus(0, 0, 4'h7, 8'h42);
    idle(2);
    applyStimulus(1, 0, 4'h7, 8'h42);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checkOutput("reenter cpu_rst_n", cpu_rst_n, 0);
      checkOutput("reenter cpu_halt", cpu_halt, 1);
    end
    checkOutput("reenter wr_count", wr_count, 0);

    // Randomized pin traffic against the model
    p = 1; b = 0; seg = 3; a = '0; d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 59) == 0) p = !p;
      if (seg == 0) begin
        b = !b;
        seg = $urandom_range(1, 12);
      end
      seg--;
      if ($urandom_range(0, 7) == 0) begin
        a = 4'($urandom);
        d = 8'($urandom);
      end
      applyStimulus(p, b, a, d);
    end

    // Saturation of wr_count
    applyStimulus(0, 0, 4'h0, 8'h00);
    idle(12);
    applyStimulus(1, 0, 4'h0, 8'h00);
    idle(4);
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(1, 0, 4'(k), 8'(k));
      pressButton(8, 5, lat);
      if (k == 254 || k == 255 || k == 260) checkOutput("saturate wr_count", wr_count, (k > 255) ? 255 : k);
    end

    // Reset asserted while the strobe is high
    applyStimulus(1, 1, 4'hC, 8'hC3);
    edgesUntil(0, 30, n);
    checkOutput("abort write edge", n, 7);
    #2 rst_n = 1'b0;
    #1 checkResetValues("abort");
    applyStimulus(0, 0, 4'h0, 8'h00);
    rst_n = 1'b1;
    idle(8);
    checkOutput("post-abort cpu_rst_n", cpu_rst_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected it to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
